// File: rtl/res_fifo_pkg.sv
// Shared constants for the result FIFO.
// WIDTH_DEF : default data width of result_in / result_out.
// DEPTH_DEF : default number of storage entries.
package res_fifo_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 3;

endpackage : res_fifo_pkg

// File: rtl/res_fifo.sv
// Result FIFO: a small circular buffer that queues results and presents the
// most recently popped entry on a registered output.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   n_rst      : synchronous reset, active-high despite the name
//   wenable    : push result_in this cycle (dropped when full without a read)
//   renable    : pop head entry into result_out this cycle (ignored when empty)
//   result_in  : data to push
//   empty      : high while the FIFO holds no entries
//   result_out : last popped entry, held between successful reads
module res_fifo
  import res_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wenable,
  input  logic             renable,
  input  logic [WIDTH-1:0] result_in,
  output logic             empty,
  output logic [WIDTH-1:0] result_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;
  logic             do_wr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // A read in the same cycle frees the head slot, so a full FIFO still
  // accepts a write when it is also being read.
  always_comb begin
    do_rd = renable && (count != '0);
    do_wr = wenable && ((count < DEPTH_C) || do_rd);
  end

  assign empty = (count == '0);

  // Storage is never reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_wr && !n_rst) begin
      mem[wr_ptr] <= result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      result_out <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr     <= ptr_next(rd_ptr);
        result_out <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : res_fifo

// File: tb/tb_res_fifo.sv
// Directed bench for res_fifo with a queue model and read scoreboard.
module tb_res_fifo;
  import res_fifo_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int D = DEPTH_DEF;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         wenable = 1'b0;
  logic         renable = 1'b0;
  logic [W-1:0] result_in = '0;
  logic         empty;
  logic [W-1:0] result_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];   // model contents
  logic [W-1:0] sb[$];   // expected read data
  logic [W-1:0] last_out = '0;

  res_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wenable    (wenable),
    .renable    (renable),
    .result_in  (result_in),
    .empty      (empty),
    .result_out (result_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; model updated, outputs checked #1 after edge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    bit rd, wr;
    logic [W-1:0] e;
    wenable = w; renable = r; result_in = d;
    rd = r && (mq.size() > 0);
    wr = w && ((mq.size() < D) || rd);
    if (rd) sb.push_back(mq.pop_front());
    if (wr) mq.push_back(d);
    @(posedge clk); #1;
    wenable = 1'b0; renable = 1'b0;
    if (rd) begin
      e = sb.pop_front();
      last_out = e;
      chk("read_data", result_out, e);
    end else begin
      chk("hold_out", result_out, last_out);
    end
    chk("empty_flag", empty, (mq.size() == 0));
  endtask

  task automatic do_reset(input int n, input logic w, input logic r);
    n_rst = 1'b1; wenable = w; renable = r; result_in = 16'd999;
    repeat (n) @(posedge clk);
    #1;
    n_rst = 1'b0; wenable = 1'b0; renable = 1'b0;
    mq.delete(); sb.delete(); last_out = '0;
    chk("rst_empty", empty, 1);
    chk("rst_out", result_out, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    #1;
    do_reset(2, 1'b0, 1'b0);

    // read on empty after reset
    step(0, 1, 0);
    chk("rd_empty_out", result_out, 0);
    chk("rd_empty_flag", empty, 1);

    // gapped writes, reads held
    step(1, 0, 68);
    step(1, 0, 2021);
    repeat (3) step(0, 0, 572);
    step(1, 0, 984);
    step(0, 1, 0); chk("gap_r1", result_out, 68);   chk("gap_e1", empty, 0);
    step(0, 1, 0); chk("gap_r2", result_out, 2021); chk("gap_e2", empty, 0);
    step(0, 1, 0); chk("gap_r3", result_out, 984);  chk("gap_e3", empty, 1);

    // pulsed reads
    do_reset(1, 1'b0, 1'b0);
    step(1, 0, 68); step(1, 0, 2021); step(1, 0, 984);
    chk("pulse_pre", result_out, 0);
    step(0, 1, 0); chk("pulse_r1", result_out, 68);
    step(0, 0, 0); chk("pulse_hold", result_out, 68);
    step(0, 1, 0); chk("pulse_r2", result_out, 2021);
    step(0, 1, 0); chk("pulse_r3", result_out, 984); chk("pulse_e", empty, 1);

    // write when full is dropped
    do_reset(1, 1'b0, 1'b0);
    step(1, 0, 68); step(1, 0, 2021); step(1, 0, 984);
    step(1, 0, 555);
    step(0, 1, 0); chk("full_r1", result_out, 68);
    step(0, 1, 0); chk("full_r2", result_out, 2021);
    step(0, 1, 0); chk("full_r3", result_out, 984); chk("full_e", empty, 1);
    step(0, 1, 0); chk("full_extra", result_out, 984);

    // simultaneous with one entry
    do_reset(1, 1'b0, 1'b0);
    step(1, 0, 68);
    step(1, 1, 77); chk("sim_r1", result_out, 68); chk("sim_e1", empty, 0);
    step(0, 1, 0);  chk("sim_r2", result_out, 77); chk("sim_e2", empty, 1);

    // simultaneous on empty: write only
    step(1, 1, 42); chk("sim_empty_out", result_out, 77); chk("sim_empty_e", empty, 0);
    step(0, 1, 0);  chk("sim_empty_rd", result_out, 42);

    // simultaneous when full, then dropped write confirms still full
    step(1, 0, 1); step(1, 0, 2); step(1, 0, 3);
    step(1, 1, 4); chk("simfull_r", result_out, 1);
    step(1, 0, 5);
    step(0, 1, 0); chk("simfull_a", result_out, 2);
    step(0, 1, 0); chk("simfull_b", result_out, 3);
    step(0, 1, 0); chk("simfull_c", result_out, 4); chk("simfull_e", empty, 1);

    // wrap-around: push/pop pairs
    for (int i = 0; i < 5; i++) begin
      v = W'($urandom_range(0, 65535));
      step(1, 0, v);
      step(0, 1, 0);
      chk("wrap_data", result_out, v);
    end

    // reset mid-operation overrides requests and discards entries
    step(1, 0, 11); step(1, 0, 22);
    do_reset(2, 1'b1, 1'b1);
    step(0, 1, 0); chk("midrst_out", result_out, 0); chk("midrst_e", empty, 1);
    step(1, 0, 33);
    step(0, 1, 0); chk("post_rst", result_out, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_res_fifo
